rcc_lsecss_monitor: RTL and testbench
=====================================

Name: rcc_lsecss_monitor

Overview:
- LSE clock security system (CSS) detector. It produces the `lsecss_fail` indication consumed by the RTC kernel clock switch and LSE gating logic.
- Runs on the LSI clock. It watches a divided LSE toggle that is launched in the LSE domain, and declares LSE failure when no toggle edge arrives within a programmable LSI-cycle window.
- Failure is sticky until backup-domain reset. A one-cycle interrupt pulse is raised at detection.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `lse_div_tog` (minimum 2).
- CNT_W, 6, width of the LSI-cycle watchdog counter.
- TIMEOUT, 40, LSI cycles without a synchronized toggle edge that declare failure (must be < 2^CNT_W).
- ARM_EDGES, 4, consecutive good edges required before monitoring starts.

Ports:
- lsi_clk, input, 1, monitor clock (LSI, VDD domain).
- rst_n, input, 1, synchronous active-low reset (backup-domain reset, already synchronized to `lsi_clk`).
- lse_div_tog, input, 1, toggle flop output from the LSE domain; inverts once every 4 LSE cycles; asynchronous to `lsi_clk`.
- lsecsson, input, 1, CSS enable from the backup domain control register (software sets it, and it is cleared only by reset).
- lse_rdy, input, 1, LSE ready flag; treated as a quasi-static level.
- lsecss_fail, output, 1, sticky LSE failure level, driven to the RTC clock switch `clk_fail` input.
- lsecss_irq, output, 1, single-cycle pulse at failure detection.
- lsecss_armed, output, 1, high while in MONITOR state (status readback).

Behaviour:
- Reset (`rst_n`=0 at a `lsi_clk` rising edge):
  - state=IDLE.
  - Synchronizer flops, edge-history flop, counter and edge counter all reset to 0.
  - `lsecss_fail`=0, `lsecss_irq`=0, `lsecss_armed`=0.
  - Reset wins over every other event in the same cycle, including a failure detected in that cycle.
- Synchronizer and edge detect:
  - `lse_div_tog` passes through SYNC_STAGES flops, then one history flop.
  - `edge` = XOR of the last sync stage and the history flop. Both polarities count.
  - Latency from an input change to `edge`: SYNC_STAGES+1 cycles.
- Counter: saturates at 2^CNT_W-1, never wraps. It clears to 0 on `edge` or on any state change.
- State machine, evaluated each cycle:
  - IDLE: counter and edge counter held at 0. Go to ARM when `lsecsson`=1 and `lse_rdy`=1.
  - ARM:
    - `edge`: edge counter increments; counter clears.
    - No edge: counter increments.
    - If counter reaches TIMEOUT, clear the edge counter and stay in ARM. No failure is reported in ARM, because the LSE is still settling.
    - When the edge counter reaches ARM_EDGES, go to MONITOR.
    - If `lsecsson`=0 or `lse_rdy`=0, go to IDLE.
  - MONITOR:
    - `lsecss_armed`=1.
    - `edge` clears the counter; otherwise the counter increments.
    - When counter == TIMEOUT-1 and there is no edge this cycle, go to FAIL next cycle.
    - `lse_rdy` falling does NOT leave MONITOR: a dropped ready is itself a failure symptom.
    - `lsecsson`=0 (reset-only case) goes to IDLE.
  - FAIL:
    - `lsecss_fail`=1 from the first FAIL cycle until reset.
    - `lsecss_irq`=1 for exactly the first FAIL cycle.
    - All inputs are ignored. Only `rst_n` exits FAIL.
- Timing:
  - Failure declared exactly TIMEOUT cycles after the last accepted edge. `lsecss_fail` rises at the edge ending cycle TIMEOUT.
  - An edge arriving in the same cycle the counter hits TIMEOUT-1 prevents failure (edge has priority).
- All outputs are registered. `lsecss_fail` is glitch-free because it feeds the clock-switch fail input.

Test Plan:
- Reset then idle: `rst_n`=0 for 3 cycles, `lsecsson`=0, toggle running -> state IDLE, all outputs 0, `lsecss_armed` never rises.
- Arm and monitor: `lsecsson`=1, `lse_rdy`=1, toggle period 8 LSI cycles (edge every 8) -> `lsecss_armed`=1 after the 4th synchronized edge. `lsecss_fail` stays 0 over 1000 cycles.
- Stop LSE in MONITOR: freeze `lse_div_tog` -> `lsecss_fail` rises exactly 40 cycles after the last synchronized edge. `lsecss_irq` high for 1 cycle. `lsecss_armed`=0.
- Boundary edge: in MONITOR, place an edge in the cycle counter==39 -> no failure; counter restarts. Place it at counter==40 -> failure already latched; edge ignored.
- Slow startup: in ARM, gaps of 45 cycles between edges -> edge counter keeps clearing, no MONITOR entry, no fail. Then 4 edges at an 8-cycle spacing -> MONITOR.
- Sticky and reset: in FAIL, toggle `lse_div_tog`, drop `lse_rdy` and `lsecsson` -> `lsecss_fail` stays 1. Assert `rst_n`=0 for one cycle -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/rcc_lsecss_monitor.sv
// LSE clock security system: watches a divided LSE toggle from the LSI domain
// and latches a sticky failure when the toggle stops for TIMEOUT LSI cycles.
module rcc_lsecss_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6,
  parameter int TIMEOUT     = 40,
  parameter int ARM_EDGES   = 4
) (
  input  logic lsi_clk,
  input  logic rst_n,
  input  logic lse_div_tog,
  input  logic lsecsson,
  input  logic lse_rdy,
  output logic lsecss_fail,
  output logic lsecss_irq,
  output logic lsecss_armed
);

  localparam int                ECNT_W   = $clog2(ARM_EDGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TMO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [ECNT_W-1:0] EDGES_M1 = ECNT_W'(ARM_EDGES - 1);

  typedef enum logic [1:0] {IDLE, ARM, MONITOR, FAIL} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    hist_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [ECNT_W-1:0]       ecnt_q, ecnt_d;
  logic                    fail_q, fail_d;
  logic                    irq_q, irq_d;
  logic                    armed_q, armed_d;
  logic                    tog_edge;

  // Either polarity of the synchronized toggle is one LSE activity edge.
  assign tog_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        ecnt_d = '0;
        if (lsecsson && lse_rdy) state_d = ARM;
      end
      ARM: begin
        if (tog_edge) begin
          cnt_d  = '0;
          ecnt_d = ecnt_q + 1'b1;
          if (ecnt_q >= EDGES_M1) state_d = MONITOR;
        end else if (cnt_q >= TMO) begin
          // LSE still settling: a long gap restarts the good-edge run.
          ecnt_d = '0;
        end
        if (!lsecsson || !lse_rdy) state_d = IDLE;
      end
      MONITOR: begin
        if (tog_edge)             cnt_d   = '0;
        else if (cnt_q == TMO_M1) state_d = FAIL;
        if (!lsecsson) state_d = IDLE;
      end
      FAIL: cnt_d = cnt_q;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d  = '0;
      ecnt_d = '0;
    end
    fail_d  = (state_d == FAIL);
    irq_d   = (state_d == FAIL) && (state_q != FAIL);
    armed_d = (state_d == MONITOR);
  end

  // NOTE: every flop is cleared by reset so reset also overrides a failure
  // detected in the same cycle; sequential state uses non-blocking updates.
  always_ff @(posedge lsi_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      fail_q  <= 1'b0;
      irq_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], lse_div_tog};
      hist_q  <= sync_q[SYNC_STAGES-1];
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      fail_q  <= fail_d;
      irq_q   <= irq_d;
      armed_q <= armed_d;
    end
  end

  assign lsecss_fail  = fail_q;
  assign lsecss_irq   = irq_q;
  assign lsecss_armed = armed_q;

endmodule

// File: tb/tb_rcc_lsecss_monitor.sv
// Directed bench for rcc_lsecss_monitor: expected {fail,irq,armed} values are
// queued with their due cycle when stimulus is driven and checked when due.
module tb_rcc_lsecss_monitor;

  logic lsi_clk = 1'b0;
  logic rst_n, lse_div_tog, lsecsson, lse_rdy;
  logic lsecss_fail, lsecss_irq, lsecss_armed;

  typedef struct {
    int         cyc;
    logic [2:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  rcc_lsecss_monitor dut (
    .lsi_clk      (lsi_clk),
    .rst_n        (rst_n),
    .lse_div_tog  (lse_div_tog),
    .lsecsson     (lsecsson),
    .lse_rdy      (lse_rdy),
    .lsecss_fail  (lsecss_fail),
    .lsecss_irq   (lsecss_irq),
    .lsecss_armed (lsecss_armed)
  );

  always #5 lsi_clk = ~lsi_clk;

  task automatic expect_at(input int dly, input logic f, input logic i,
                           input logic a, input string tag);
    sb_t e;
    e.cyc = cyc + dly;
    e.exp = {f, i, a};
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one cycle, then compare every scoreboard entry that is due.
  task automatic tick();
    @(posedge lsi_clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        sb_t        e;
        logic [2:0] obs;
        e   = sb[i];
        obs = {lsecss_fail, lsecss_irq, lsecss_armed};
        sb.delete(i);
        checks++;
        assert (obs === e.exp && e.cyc == cyc) else begin
          errors++;
          $error("FAIL %s cyc=%0d fail/irq/armed observed=%b expected=%b",
                 e.tag, cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic tog();
    lse_div_tog = ~lse_div_tog;
  endtask

  task automatic do_reset(input string tag);
    lsecsson = 1'b0;
    lse_rdy  = 1'b0;
    rst_n    = 1'b0;
    expect_at(1, 1'b0, 1'b0, 1'b0, tag);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  // Four edges at 8-cycle spacing; MONITOR is entered as the 4th is accepted.
  task automatic arm_fast(input string tag);
    lsecsson = 1'b1;
    lse_rdy  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      repeat (8) tick();
      tog();
      if (k < 4) begin
        expect_at(3, 1'b0, 1'b0, 1'b0, {tag, "_prearm"});
      end else begin
        expect_at(2, 1'b0, 1'b0, 1'b0, {tag, "_before_armed"});
        expect_at(3, 1'b0, 1'b0, 1'b1, {tag, "_armed"});
      end
    end
  endtask

  initial begin
    int guard;
    rst_n       = 1'b0;
    lsecsson    = 1'b0;
    lse_rdy     = 1'b0;
    lse_div_tog = 1'b0;

    // Reset with the toggle running, then IDLE with CSS disabled.
    for (int k = 0; k < 3; k++) begin
      expect_at(1, 1'b0, 1'b0, 1'b0, "reset");
      tick();
      if (k == 1) tog();
    end
    rst_n   = 1'b1;
    lse_rdy = 1'b1;
    for (int k = 0; k < 28; k++) begin
      expect_at(1, 1'b0, 1'b0, 1'b0, "idle");
      tick();
      if (k % 4 == 3 && k < 24) tog();
    end

    // Arm, then monitor a healthy LSE for 1000 cycles.
    arm_fast("arm");
    for (int k = 0; k < 125; k++) begin
      repeat (8) tick();
      tog();
      expect_at(3, 1'b0, 1'b0, 1'b1, "monitor_ok");
    end

    // Freeze the LSE and drop ready: ready alone does not leave MONITOR.
    lse_rdy = 1'b0;
    expect_at(20, 1'b0, 1'b0, 1'b1, "rdy_low_still_armed");
    expect_at(42, 1'b0, 1'b0, 1'b1, "pre_fail");
    expect_at(43, 1'b1, 1'b1, 1'b0, "fail_rise");
    expect_at(44, 1'b1, 1'b0, 1'b0, "irq_one_cycle");
    repeat (50) tick();

    // Edge while counter==TIMEOUT-1 rescues; one cycle later it is too late.
    do_reset("reset2");
    arm_fast("arm2");
    repeat (40) tick();
    tog();
    expect_at(3, 1'b0, 1'b0, 1'b1, "edge_at_tmo_m1");
    expect_at(30, 1'b0, 1'b0, 1'b1, "counter_restarted");
    repeat (41) tick();
    tog();
    expect_at(1, 1'b0, 1'b0, 1'b1, "late_edge_pre_fail");
    expect_at(2, 1'b1, 1'b1, 1'b0, "late_edge_fail");
    expect_at(5, 1'b1, 1'b0, 1'b0, "late_edge_ignored");
    repeat (8) tick();

    // Reset in the very cycle a failure would be declared.
    do_reset("reset3");
    arm_fast("arm3");
    expect_at(42, 1'b0, 1'b0, 1'b1, "pre_fail_rst");
    repeat (42) tick();
    rst_n    = 1'b0;
    lsecsson = 1'b0;
    expect_at(1, 1'b0, 1'b0, 1'b0, "reset_wins");
    tick();
    rst_n = 1'b1;
    expect_at(4, 1'b0, 1'b0, 1'b0, "post_reset_idle");
    repeat (5) tick();

    // Slow startup: 45-cycle gaps never arm; then a fast burst does.
    do_reset("reset4");
    lsecsson = 1'b1;
    lse_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (45) tick();
      tog();
      expect_at(3, 1'b0, 1'b0, 1'b0, "slow_no_arm");
      expect_at(30, 1'b0, 1'b0, 1'b0, "slow_no_arm_mid");
    end
    repeat (37) tick();
    arm_fast("arm_after_slow");

    // Fail, then show the failure is sticky against every input.
    expect_at(43, 1'b1, 1'b1, 1'b0, "fail_rise2");
    expect_at(44, 1'b1, 1'b0, 1'b0, "irq_one_cycle2");
    repeat (43) tick();
    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 0) tog();
      if (k == 5) lse_rdy = 1'b0;
      if (k == 10) lsecsson = 1'b0;
      expect_at(1, 1'b1, 1'b0, 1'b0, "sticky");
      tick();
    end
    rst_n = 1'b0;
    expect_at(1, 1'b0, 1'b0, 1'b0, "fail_cleared");
    tick();
    rst_n = 1'b1;
    expect_at(3, 1'b0, 1'b0, 1'b0, "idle_after_clear");
    repeat (4) tick();

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
